decode_scoreboard: RTL and testbench
====================================

DECODE_SCOREBOARD -- requirements
Module: decode_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 16, the number of architectural registers tracked; register addresses are 4 bits wide.
REQ-002 SHALL have parameter CNTW, default 2, the width of each per-register outstanding-write counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-005 SHALL have port issue_valid, input, 1 bit: decode presents an instruction this cycle.
REQ-006 SHALL have port issue_wr, input, 1 bit: the presented instruction writes issue_rd.
REQ-007 SHALL have port issue_rd, input, 4 bits: destination register (Rd) of the presented instruction.
REQ-008 SHALL have ports src_a and src_b, input, 4 bits each: read addresses driven to the register file (A1, A2).
REQ-009 SHALL have ports src_a_use and src_b_use, input, 1 bit each: the corresponding source is actually read.
REQ-010 SHALL have ports wb_valid (input, 1 bit) and wb_rd (input, 4 bits): register-file write completing this cycle (regWrite, A3).
REQ-011 SHALL have ports flush (input, 1 bit), which squashes in-flight writes, and drain_req (input, 1 bit), which requests a pipeline drain.
REQ-012 SHALL have ports stall (output, 1 bit), drain_done (output, 1 bit), busy_mask (output, 16 bits, bit i set when counter i is nonzero) and stall_cycles (output, 16 bits).

Function
REQ-013 SHALL keep one CNTW-bit counter per register, counting issued-but-not-written-back writes.
REQ-014 SHALL define hazard = issue_valid and (src_a_use and cnt[src_a]!=0, or src_b_use and cnt[src_b]!=0, or issue_wr and cnt[issue_rd] is at its maximum value).
REQ-015 SHALL never treat register 15 (PC) as a hazard for a source, since its value is supplied by the PC.
REQ-016 SHALL compute stall combinationally, in the same cycle, as hazard in state RUN or STALL, and as 1 throughout state DRAIN.
REQ-017 SHALL define accept = issue_valid and not stall; on accept with issue_wr, cnt[issue_rd] increments by 1.
REQ-018 SHALL decrement cnt[wb_rd] by 1 on wb_valid; a writeback to a register whose counter is zero SHALL leave it at zero.
REQ-019 SHALL leave a counter unchanged when an accepted increment and a writeback target the same register in the same cycle.
REQ-020 SHALL implement FSM states RUN, STALL and DRAIN.
REQ-021 SHALL use the following transitions: RUN to STALL on hazard; STALL to RUN when hazard is 0; RUN or STALL to DRAIN on drain_req.
REQ-022 SHALL leave DRAIN for RUN in the cycle after all counters reach zero, pulsing drain_done high for exactly that one cycle.
REQ-023 SHALL, on flush, zero every counter and enter RUN on the next edge; flush has priority over drain_req, issue and writeback.
REQ-024 SHALL abort a drain when flush arrives during DRAIN, without pulsing drain_done.
REQ-025 SHALL increment stall_cycles every cycle stall=1, saturating at 0xFFFF; flush does not clear it.

Reset
REQ-026 SHALL, on a clock edge with rst_n=0, set all counters to 0, state to RUN, stall_cycles to 0 and drain_done to 0, giving busy_mask=0 and stall=0.
REQ-027 SHALL let reset asserted mid-drain or mid-stall override all other inputs, with no drain_done pulse.

Configuration
REQ-028 SHALL, when macro SCOREBOARD_WB_BYPASS_EN is defined, ignore a source hazard whose register is being written back this cycle (wb_valid, wb_rd equal to the source) with counter equal to 1.
REQ-029 SHALL, when SCOREBOARD_WB_BYPASS_EN is undefined, keep such a source hazard, holding stall for one more cycle.

Verification
REQ-030 SHALL cover RAW stall: accept issue_wr with rd=3, then issue src_a=3 -> stall=1 and state STALL until wb_valid with rd=3. With bypass, stall drops in the wb cycle; without bypass, it drops one cycle later.
REQ-031 SHALL cover PC source: cnt[15]=1 and src_a=15 with src_a_use=1 -> stall=0.
REQ-032 SHALL cover counter saturation: three accepted writes to r5 -> busy_mask bit 5 set; a fourth issue to r5 -> stall=1; one wb to r5 -> the next issue is accepted.
REQ-033 SHALL cover a simultaneous same-register increment and writeback on r2 with cnt=1 -> cnt stays 1 and busy_mask bit 2 stays set.
REQ-034 SHALL cover drain: drain_req with r1 and r4 outstanding -> stall=1 until both write back, then a single-cycle drain_done and return to RUN.
REQ-035 SHALL cover flush in DRAIN: busy_mask goes to 0 next cycle, state is RUN, no drain_done pulse, and stall_cycles is preserved.

Source files
------------

// File: rtl/decode_scoreboard_if.sv
// Decode-stage scoreboard bus: issue, source, writeback and control
// signals driven by the pipeline, status returned by the scoreboard.
interface decode_scoreboard_if;
    logic        issue_valid;
    logic        issue_wr;
    logic [3:0]  issue_rd;
    logic [3:0]  src_a;
    logic [3:0]  src_b;
    logic        src_a_use;
    logic        src_b_use;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic        flush;
    logic        drain_req;
    logic        stall;
    logic        drain_done;
    logic [15:0] busy_mask;
    logic [15:0] stall_cycles;

    modport master (
        output issue_valid, issue_wr, issue_rd, src_a, src_b, src_a_use, src_b_use,
        output wb_valid, wb_rd, flush, drain_req,
        input  stall, drain_done, busy_mask, stall_cycles
    );

    modport slave (
        input  issue_valid, issue_wr, issue_rd, src_a, src_b, src_a_use, src_b_use,
        input  wb_valid, wb_rd, flush, drain_req,
        output stall, drain_done, busy_mask, stall_cycles
    );
endinterface

// File: rtl/decode_scoreboard.sv
// Register scoreboard for the decode stage: per-register outstanding-write
// counters, RAW/WAW-overflow hazard detection, and a RUN/STALL/DRAIN FSM.
// Optional macro SCOREBOARD_WB_BYPASS_EN: a source whose only outstanding
// write is completing this cycle is not treated as a hazard.
module decode_scoreboard #(
    parameter int NREG = 16,
    parameter int CNTW = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    decode_scoreboard_if.slave   sb
);

    typedef enum logic [1:0] {RUN, STALL, DRAIN} state_t;

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    state_t                     state_reg;
    state_t                     state_next;
    logic [NREG-1:0][CNTW-1:0]  cnt_reg;
    logic [15:0]                busy;
    logic [15:0]                at_max;
    logic                       hazard;
    logic                       haz_a;
    logic                       haz_b;
    logic                       haz_wr;
    logic                       all_zero;
    logic                       accept;
    logic                       stall_next;
    logic                       drain_done_reg;
    logic [15:0]                stall_cycles_reg;

    // Per-register flags flattened to 16 bits so any 4-bit address can index them;
    // registers beyond NREG read as idle.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_flags
            if (gi < NREG) begin : g_live
                assign busy[gi]   = (cnt_reg[gi] != '0);
                assign at_max[gi] = (cnt_reg[gi] == CNT_MAX);
            end else begin : g_dead
                assign busy[gi]   = 1'b0;
                assign at_max[gi] = 1'b0;
            end
        end
    endgenerate

`ifdef SCOREBOARD_WB_BYPASS_EN
    logic [15:0] cnt_one;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_one
            if (gi < NREG) begin : g_live
                assign cnt_one[gi] = (cnt_reg[gi] == CNTW'(1));
            end else begin : g_dead
                assign cnt_one[gi] = 1'b0;
            end
        end
    endgenerate
    // A source whose last pending write lands this cycle can take the forwarded value.
    wire byp_a = sb.wb_valid && (sb.wb_rd == sb.src_a) && cnt_one[sb.src_a];
    wire byp_b = sb.wb_valid && (sb.wb_rd == sb.src_b) && cnt_one[sb.src_b];
`else
    wire byp_a = 1'b0;
    wire byp_b = 1'b0;
`endif

    // r15 is the PC and is never waited on as a source.
    assign haz_a    = sb.src_a_use && (sb.src_a != 4'd15) && busy[sb.src_a] && !byp_a;
    assign haz_b    = sb.src_b_use && (sb.src_b != 4'd15) && busy[sb.src_b] && !byp_b;
    assign haz_wr   = sb.issue_wr && at_max[sb.issue_rd];
    assign hazard   = sb.issue_valid && (haz_a || haz_b || haz_wr);
    assign all_zero = (busy == 16'd0);
    assign accept   = sb.issue_valid && !stall_next;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_reg <= RUN;
        else        state_reg <= state_next;
    end

    // Next-state logic; flush wins, then drain request, then hazard tracking
    always_comb begin
        state_next = state_reg;
        if (sb.flush) begin
            state_next = RUN;
        end else begin
            case (state_reg)
                RUN:     if (sb.drain_req) state_next = DRAIN;
                         else if (hazard)  state_next = STALL;
                STALL:   if (sb.drain_req) state_next = DRAIN;
                         else if (!hazard) state_next = RUN;
                DRAIN:   if (all_zero)     state_next = RUN;
                default: state_next = RUN;
            endcase
        end
    end

    // Output logic: stall is same-cycle; a drain blocks all issue
    always_comb begin
        stall_next = hazard;
        if (state_reg == DRAIN) stall_next = 1'b1;
    end

    // Outstanding-write counters; simultaneous issue and writeback cancel out
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (!rst_n || sb.flush) begin
                cnt_reg[i] <= '0;
            end else begin
                if ((accept && sb.issue_wr && sb.issue_rd == 4'(i)) &&
                    !(sb.wb_valid && sb.wb_rd == 4'(i)))
                    cnt_reg[i] <= cnt_reg[i] + CNTW'(1);
                else if (!(accept && sb.issue_wr && sb.issue_rd == 4'(i)) &&
                         (sb.wb_valid && sb.wb_rd == 4'(i)) && (cnt_reg[i] != '0))
                    cnt_reg[i] <= cnt_reg[i] - CNTW'(1);
            end
        end
    end

    // One-cycle drain_done as the FSM leaves DRAIN with nothing outstanding
    always_ff @(posedge clk) begin
        if (!rst_n) drain_done_reg <= 1'b0;
        else        drain_done_reg <= !sb.flush && (state_reg == DRAIN) && all_zero;
    end

    // Saturating stall counter; survives flush, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_cycles_reg <= 16'd0;
        else if (stall_next && (stall_cycles_reg != 16'hFFFF))
            stall_cycles_reg <= stall_cycles_reg + 16'd1;
    end

    assign sb.stall        = stall_next;
    assign sb.drain_done   = drain_done_reg;
    assign sb.busy_mask    = busy;
    assign sb.stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_decode_scoreboard.sv
// Bench for decode_scoreboard: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a counter model.
module tb_decode_scoreboard;

    localparam int CMAX = 3;

    logic clk;
    logic rst_n;
    decode_scoreboard_if bus ();

    decode_scoreboard #(.NREG(16), .CNTW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model: pending-write count per register, whether a drain is
    // in progress, the expected drain_done and stall counter.
    int m_cnt [16];
    bit m_drain = 1'b0;
    bit m_dd    = 1'b0;
    int m_sc    = 0;

    initial for (int i = 0; i < 16; i++) m_cnt[i] = 0;

    task automatic cmp(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic bit src_hz(input logic [3:0] s, input logic u);
        bit h;
        h = u && (s != 4'd15) && (m_cnt[s] != 0);
`ifdef SCOREBOARD_WB_BYPASS_EN
        if (bus.wb_valid && bus.wb_rd == s && m_cnt[s] == 1) h = 1'b0;
`endif
        return h;
    endfunction

    function automatic bit exp_stall();
        if (m_drain) return 1'b1;
        return bus.issue_valid && (src_hz(bus.src_a, bus.src_a_use) ||
                                   src_hz(bus.src_b, bus.src_b_use) ||
                                   (bus.issue_wr && m_cnt[bus.issue_rd] == CMAX));
    endfunction

    function automatic logic [15:0] exp_busy();
        logic [15:0] bm;
        for (int i = 0; i < 16; i++) bm[i] = (m_cnt[i] != 0);
        return bm;
    endfunction

    // Model advance on every rising edge
    always @(posedge clk) begin : model
        bit s, acc, allz, inc, dec;
        int nc;
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) m_cnt[i] <= 0;
            m_drain <= 1'b0;
            m_dd    <= 1'b0;
            m_sc    <= 0;
        end else begin
            s    = exp_stall();
            acc  = bus.issue_valid && !s;
            allz = (exp_busy() == 16'd0);
            if (s && m_sc < 65535) m_sc <= m_sc + 1;
            if (bus.flush) begin
                for (int i = 0; i < 16; i++) m_cnt[i] <= 0;
                m_drain <= 1'b0;
                m_dd    <= 1'b0;
            end else begin
                m_dd <= m_drain && allz;
                if (m_drain) begin
                    if (allz) m_drain <= 1'b0;
                end else if (bus.drain_req) begin
                    m_drain <= 1'b1;
                end
                for (int i = 0; i < 16; i++) begin
                    nc  = m_cnt[i];
                    inc = acc && bus.issue_wr && (bus.issue_rd == 4'(i));
                    dec = bus.wb_valid && (bus.wb_rd == 4'(i));
                    if (inc && !dec)                nc = nc + 1;
                    else if (dec && !inc && nc > 0) nc = nc - 1;
                    m_cnt[i] <= nc;
                end
            end
        end
    end

    // Compare process: every output against the model, mid-cycle
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("stall",        {15'd0, bus.stall},      {15'd0, exp_stall()});
            cmp("drain_done",   {15'd0, bus.drain_done}, {15'd0, m_dd});
            cmp("busy_mask",    bus.busy_mask,           exp_busy());
            cmp("stall_cycles", bus.stall_cycles,        m_sc[15:0]);
        end
    end

    task automatic idle();
        bus.issue_valid = 0; bus.issue_wr = 0; bus.issue_rd = 0;
        bus.src_a = 0; bus.src_b = 0; bus.src_a_use = 0; bus.src_b_use = 0;
        bus.wb_valid = 0; bus.wb_rd = 0; bus.flush = 0; bus.drain_req = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_wr(input logic [3:0] rd);
        idle();
        bus.issue_valid = 1; bus.issue_wr = 1; bus.issue_rd = rd;
        cyc();
    endtask

    task automatic wb(input logic [3:0] rd);
        idle();
        bus.wb_valid = 1; bus.wb_rd = rd;
        cyc();
    endtask

    function automatic logic [3:0] pick_busy();
        int off;
        off = $urandom_range(0, 15);
        for (int k = 0; k < 16; k++)
            if (m_cnt[(off + k) % 16] != 0) return 4'((off + k) % 16);
        return 4'($urandom_range(0, 15));
    endfunction

    initial begin
        idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        cmp("rst_busy",  bus.busy_mask, 16'd0);
        cmp("rst_stall", {15'd0, bus.stall}, 16'd0);
        cmp("rst_sc",    bus.stall_cycles, 16'd0);
        cmp("rst_dd",    {15'd0, bus.drain_done}, 16'd0);
        rst_n = 1;
        cyc();

        // RAW on r3
        issue_wr(4'd3);
        idle(); bus.issue_valid = 1; bus.src_a = 3; bus.src_a_use = 1;
        #1 cmp("raw_stall0", {15'd0, bus.stall}, 16'd1);
        cyc();
        cmp("raw_stall1", {15'd0, bus.stall}, 16'd1);
        bus.wb_valid = 1; bus.wb_rd = 3;
        #1;
`ifdef SCOREBOARD_WB_BYPASS_EN
        cmp("raw_wbcyc", {15'd0, bus.stall}, 16'd0);
`else
        cmp("raw_wbcyc", {15'd0, bus.stall}, 16'd1);
`endif
        cyc();
        bus.wb_valid = 0;
        #1 cmp("raw_after", {15'd0, bus.stall}, 16'd0);
        cyc();
        $display("scenario raw done");

        // PC as source
        issue_wr(4'd15);
        idle(); bus.issue_valid = 1; bus.src_a = 15; bus.src_a_use = 1;
        #1 cmp("pc_stall", {15'd0, bus.stall}, 16'd0);
        cmp("pc_busy15", {15'd0, bus.busy_mask[15]}, 16'd1);
        cyc();
        wb(4'd15);
        $display("scenario pc done");

        // Counter saturation on r5
        repeat (3) issue_wr(4'd5);
        idle(); bus.issue_valid = 1; bus.issue_wr = 1; bus.issue_rd = 5;
        #1 cmp("sat_busy5", {15'd0, bus.busy_mask[5]}, 16'd1);
        cmp("sat_stall", {15'd0, bus.stall}, 16'd1);
        bus.wb_valid = 1; bus.wb_rd = 5;
        cyc();
        bus.wb_valid = 0;
        #1 cmp("sat_accept", {15'd0, bus.stall}, 16'd0);
        cyc();
        repeat (3) wb(4'd5);
        $display("scenario saturation done");

        // Same-register increment and writeback on r2
        issue_wr(4'd2);
        idle(); bus.issue_valid = 1; bus.issue_wr = 1; bus.issue_rd = 2;
        bus.wb_valid = 1; bus.wb_rd = 2;
        cyc();
        idle();
        #1 cmp("same_busy2", {15'd0, bus.busy_mask[2]}, 16'd1);
        wb(4'd2);
        cmp("same_clear", {15'd0, bus.busy_mask[2]}, 16'd0);
        $display("scenario same-reg done");

        // Drain with r1 and r4 outstanding
        issue_wr(4'd1);
        issue_wr(4'd4);
        idle(); bus.drain_req = 1;
        cyc();
        bus.drain_req = 0;
        #1 cmp("drn_stall0", {15'd0, bus.stall}, 16'd1);
        wb(4'd1);
        cmp("drn_stall1", {15'd0, bus.stall}, 16'd1);
        wb(4'd4);
        idle();
        cmp("drn_stall2", {15'd0, bus.stall}, 16'd1);
        cmp("drn_dd0", {15'd0, bus.drain_done}, 16'd0);
        cyc();
        cmp("drn_dd1", {15'd0, bus.drain_done}, 16'd1);
        cmp("drn_run", {15'd0, bus.stall}, 16'd0);
        cyc();
        cmp("drn_dd2", {15'd0, bus.drain_done}, 16'd0);
        $display("scenario drain done");

        // Flush during drain
        issue_wr(4'd7);
        idle(); bus.drain_req = 1;
        cyc();
        idle(); bus.flush = 1;
        cyc();
        idle();
        #1 cmp("fl_busy", bus.busy_mask, 16'd0);
        cmp("fl_stall", {15'd0, bus.stall}, 16'd0);
        cmp("fl_dd", {15'd0, bus.drain_done}, 16'd0);
        cmp("fl_sc_kept", {15'd0, bus.stall_cycles != 16'd0}, 16'd1);
        cyc();
        cmp("fl_dd2", {15'd0, bus.drain_done}, 16'd0);
        $display("scenario flush-in-drain done");

        // Reset in the middle of a drain
        issue_wr(4'd6);
        idle(); bus.drain_req = 1;
        cyc();
        idle(); rst_n = 0;
        cyc();
        rst_n = 1;
        #1 cmp("mr_busy", bus.busy_mask, 16'd0);
        cmp("mr_stall", {15'd0, bus.stall}, 16'd0);
        cmp("mr_sc", bus.stall_cycles, 16'd0);
        cyc();
        cmp("mr_dd", {15'd0, bus.drain_done}, 16'd0);
        $display("scenario reset-in-drain done");

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            bus.issue_valid = ($urandom_range(0, 99) < 60);
            bus.issue_wr    = ($urandom_range(0, 99) < 70);
            bus.issue_rd    = 4'($urandom_range(0, 15));
            bus.src_a       = ($urandom_range(0, 1) != 0) ? pick_busy() : 4'($urandom_range(0, 15));
            bus.src_b       = 4'($urandom_range(0, 15));
            bus.src_a_use   = ($urandom_range(0, 1) != 0);
            bus.src_b_use   = ($urandom_range(0, 1) != 0);
            bus.wb_valid    = ($urandom_range(0, 99) < 45);
            bus.wb_rd       = ($urandom_range(0, 3) != 0) ? pick_busy() : 4'($urandom_range(0, 15));
            bus.flush       = ($urandom_range(0, 99) < 2);
            bus.drain_req   = ($urandom_range(0, 99) < 3);
            rst_n           = ($urandom_range(0, 299) != 0);
            cyc();
        end
        idle();
        rst_n = 1;
        repeat (4) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
